// File: rtl/simple_isa_pkg.sv
// Shared ISA definitions for the fetch stage: widths, opcodes and fetch FSM states.
package simple_isa_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    OPC_HALT = 4'h0,
    OPC_MOV  = 4'h3,
    OPC_ADD  = 4'h4,
    OPC_SUB  = 4'h5,
    OPC_JNZ  = 4'h9
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4] == OPC_HALT;
  endfunction

endpackage

// File: rtl/simple_fetch_skid.sv
// One-entry hold register that parks the presented instruction while decode stalls.
module simple_fetch_skid
  import simple_isa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               hold_v,
  output logic [INSTR_W-1:0] hold_instr,
  output logic [ADDR_W-1:0]  hold_pc
);

  logic capture;

  // Re-capturing an already held item is harmless: the data fed back is the held data.
  assign capture = in_valid && !in_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v     <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      hold_v <= capture;
      if (capture) begin
        hold_instr <= in_instr;
        hold_pc    <= in_pc;
      end
    end
  end

endmodule

// File: rtl/simple_fetch.sv
// Sequential instruction fetch with zero-bubble redirect, halt detection and a
// one-entry hold register in front of decode.
module simple_fetch
  import simple_isa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic [ADDR_W-1:0]  fetch_pc,
  output logic               halted
);

  fetch_state_e       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic               rsp_v_reg;
  logic [ADDR_W-1:0]  rsp_pc_reg;
  logic               hold_v;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc;
  logic               halt_seen;
  logic               issue;

  simple_fetch_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .in_valid   (fetch_valid),
    .in_ready   (fetch_ready),
    .in_instr   (fetch_instr),
    .in_pc      (fetch_pc),
    .hold_v     (hold_v),
    .hold_instr (hold_instr),
    .hold_pc    (hold_pc)
  );

  // Datapath toward ROM and decode; reset suppresses any transfer in its own cycle.
  always_comb begin
    instr_addr  = redirect_valid ? redirect_pc : pc_reg;
    fetch_valid = (hold_v || rsp_v_reg) && !redirect_valid && !reset;
    fetch_instr = '0;
    fetch_pc    = '0;
    if (hold_v) begin
      fetch_instr = hold_instr;
      fetch_pc    = hold_pc;
    end else if (rsp_v_reg) begin
      fetch_instr = INSTR;
      fetch_pc    = rsp_pc_reg;
    end
    halt_seen = fetch_valid && is_halt(fetch_instr);
    issue     = (state_reg == ST_RUN || redirect_valid) &&
                !(fetch_valid && (!fetch_ready || halt_seen));
    halted    = (state_reg == ST_HALT);
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (redirect_valid) begin
      state_next = ST_RUN;
    end else begin
      unique case (state_reg)
        ST_IDLE: if (start) begin
          state_next = ST_RUN;
          pc_next    = '0;
        end
        ST_RUN:  if (halt_seen && fetch_ready) state_next = ST_HALT;
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_IDLE;
      endcase
    end
    // Issue can only happen in RUN or on redirect, never alongside the start load.
    if (issue) pc_next = instr_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= '0;
      rsp_v_reg  <= 1'b0;
      rsp_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      rsp_v_reg <= issue;
      if (issue) rsp_pc_reg <= instr_addr;
    end
  end

endmodule

// File: tb/tb_simple_fetch.sv
// Self-checking bench for simple_fetch: external ROM model plus a protocol-level
// reference model of which instruction decode should see on every cycle.
module tb_simple_fetch;
  import simple_isa_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, redirect_valid = 1'b0, fetch_ready = 1'b1;
  logic [7:0]  redirect_pc = 8'd0;
  logic [7:0]  instr_addr, fetch_pc;
  logic [15:0] INSTR, fetch_instr;
  logic        fetch_valid, halted;

  logic [15:0] rom [256];
  logic [15:0] prog [9];
  int checks = 0, errors = 0, cyc = 0;

  // Reference model: program-order stream with a start-up latency.
  bit         m_idle = 1'b1, m_running = 1'b0, m_halted = 1'b0;
  int         m_live_from = 0;
  logic [7:0] m_pc = 8'd0;
  bit         exp_v, exp_halted;
  logic [7:0] exp_pc;
  logic [15:0] exp_instr;

  always #5 clk = ~clk;
  always @(posedge clk) INSTR <= rom[instr_addr];

  simple_fetch dut (
    .clk(clk), .reset(reset), .start(start), .instr_addr(instr_addr), .INSTR(INSTR),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .halted(halted)
  );

  always @(negedge clk) begin
    checks++;
    if (dut.hold_v && dut.rsp_v_reg) begin
      errors++;
      $display("FAIL hold_rsp_exclusive cyc=%0d hold_v=%b rsp_v=%b required not both", cyc, dut.hold_v, dut.rsp_v_reg);
    end
  end

  task automatic drive(input logic rs, input logic st, input logic rv, input logic rdy, input logic [7:0] rp);
    reset = rs; start = st; redirect_valid = rv; fetch_ready = rdy; redirect_pc = rp;
    exp_v      = !rs && m_running && (cyc >= m_live_from) && !rv;
    exp_pc     = m_pc;
    exp_instr  = rom[m_pc];
    exp_halted = m_halted;
    @(negedge clk);
  endtask

  task automatic advance();
    if (reset) begin
      m_idle = 1'b1; m_running = 1'b0; m_halted = 1'b0;
    end else if (redirect_valid) begin
      m_idle = 1'b0; m_running = 1'b1; m_halted = 1'b0; m_live_from = cyc + 1; m_pc = redirect_pc;
    end else if (m_idle && start) begin
      m_idle = 1'b0; m_running = 1'b1; m_live_from = cyc + 2; m_pc = 8'd0;
    end else if (exp_v && fetch_ready) begin
      if (rom[m_pc][15:12] == 4'h0) begin m_running = 1'b0; m_halted = 1'b1; end
      else m_pc = m_pc + 8'd1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) rom[i] = (i < 9) ? prog[i] : (16'h3000 | 16'(i));
  endtask

  task automatic reset_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    advance();
  endtask

  task automatic test_reset();
    load_prog();
    reset_cycle();
    reset_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    checks += 5;
    if (instr_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got=%h exp=00", instr_addr); end
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
    if (fetch_instr !== 16'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0000", fetch_instr); end
    if (fetch_pc !== 8'd0) begin errors++; $display("FAIL reset_pc got=%h exp=00", fetch_pc); end
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    advance();
  endtask

  task automatic test_program();
    for (int c = 0; c < 14; c++) begin
      logic v_req;
      v_req = (c >= 2 && c <= 10);
      drive(1'b0, c == 0, 1'b0, 1'b1, 8'd0);
      checks += 2;
      if (fetch_valid !== v_req) begin errors++; $display("FAIL prog_valid c=%0d got=%b exp=%b", c, fetch_valid, v_req); end
      if (halted !== (c >= 11)) begin errors++; $display("FAIL prog_halted c=%0d got=%b exp=%b", c, halted, c >= 11); end
      if (v_req) begin
        checks++;
        if (fetch_pc !== 8'(c - 2) || fetch_instr !== prog[c-2])
          begin errors++; $display("FAIL prog_data c=%0d got=%h/%h exp=%h/%h", c, fetch_pc, fetch_instr, 8'(c - 2), prog[c-2]); end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    reset_cycle();
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, c == 0, 1'b0, !(c >= 6 && c <= 8), 8'd0);
      checks += 2;
      if (fetch_valid !== exp_v) begin errors++; $display("FAIL stall_valid c=%0d got=%b exp=%b", c, fetch_valid, exp_v); end
      if (halted !== exp_halted) begin errors++; $display("FAIL stall_halted c=%0d got=%b exp=%b", c, halted, exp_halted); end
      if (exp_v) begin
        checks++;
        if ({fetch_pc, fetch_instr} !== {exp_pc, exp_instr})
          begin errors++; $display("FAIL stall_data c=%0d got=%h/%h exp=%h/%h", c, fetch_pc, fetch_instr, exp_pc, exp_instr); end
      end
      if (c == 9 || c == 10) begin
        checks++;
        if (!fetch_valid || fetch_pc !== 8'(c - 5))
          begin errors++; $display("FAIL stall_order c=%0d got=%b/%h exp=1/%h", c, fetch_valid, fetch_pc, 8'(c - 5)); end
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    reset_cycle();
    for (int c = 0; c < 18; c++) begin
      drive(1'b0, c == 0, c == 9, 1'b1, 8'd4);
      checks += 2;
      if (fetch_valid !== exp_v) begin errors++; $display("FAIL redir_valid c=%0d got=%b exp=%b", c, fetch_valid, exp_v); end
      if (halted !== exp_halted) begin errors++; $display("FAIL redir_halted c=%0d got=%b exp=%b", c, halted, exp_halted); end
      if (exp_v) begin
        checks++;
        if ({fetch_pc, fetch_instr} !== {exp_pc, exp_instr})
          begin errors++; $display("FAIL redir_data c=%0d got=%h/%h exp=%h/%h", c, fetch_pc, fetch_instr, exp_pc, exp_instr); end
      end
      if (c == 10) begin
        checks++;
        if (!fetch_valid || fetch_pc !== 8'd4 || fetch_instr !== 16'h4031)
          begin errors++; $display("FAIL redir_target got=%b/%h/%h exp=1/04/4031", fetch_valid, fetch_pc, fetch_instr); end
      end
      advance();
    end
  endtask

  task automatic test_halt_redirect();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b1, c == 0, 1'b1, 8'd0);
      checks += 2;
      if (fetch_valid !== exp_v) begin errors++; $display("FAIL hredir_valid c=%0d got=%b exp=%b", c, fetch_valid, exp_v); end
      if (halted !== exp_halted) begin errors++; $display("FAIL hredir_halted c=%0d got=%b exp=%b", c, halted, exp_halted); end
      if (exp_v) begin
        checks++;
        if ({fetch_pc, fetch_instr} !== {exp_pc, exp_instr})
          begin errors++; $display("FAIL hredir_data c=%0d got=%h/%h exp=%h/%h", c, fetch_pc, fetch_instr, exp_pc, exp_instr); end
      end
      if (c == 0 || c == 1) begin
        checks++;
        if (halted !== (c == 0) || (c == 1 && (!fetch_valid || fetch_instr !== 16'h300a)))
          begin errors++; $display("FAIL hredir_resume c=%0d got=%b/%b/%h exp=%b/%b/300a", c, halted, fetch_valid, fetch_instr, c == 0, c == 1); end
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    reset_cycle();
    for (int i = 0; i < 256; i++) rom[i] = 16'h3000 | 16'(i);
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, c == 0, 1'b1, 8'd255);
      checks++;
      if (fetch_valid !== exp_v) begin errors++; $display("FAIL wrap_valid c=%0d got=%b exp=%b", c, fetch_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if ({fetch_pc, fetch_instr} !== {exp_pc, exp_instr})
          begin errors++; $display("FAIL wrap_data c=%0d got=%h/%h exp=%h/%h", c, fetch_pc, fetch_instr, exp_pc, exp_instr); end
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (fetch_pc !== ((c == 1) ? 8'd255 : 8'd0))
          begin errors++; $display("FAIL wrap_pc c=%0d got=%h exp=%h", c, fetch_pc, (c == 1) ? 8'd255 : 8'd0); end
      end
      advance();
    end
  endtask

  task automatic test_reset_hold();
    load_prog();
    reset_cycle();
    for (int c = 0; c < 13; c++) begin
      drive(c == 6, c == 0 || c == 8, 1'b0, !(c >= 4 && c <= 6), 8'd0);
      checks += 2;
      if (fetch_valid !== exp_v) begin errors++; $display("FAIL rsthold_valid c=%0d got=%b exp=%b", c, fetch_valid, exp_v); end
      if (halted !== exp_halted) begin errors++; $display("FAIL rsthold_halted c=%0d got=%b exp=%b", c, halted, exp_halted); end
      if (exp_v) begin
        checks++;
        if ({fetch_pc, fetch_instr} !== {exp_pc, exp_instr})
          begin errors++; $display("FAIL rsthold_data c=%0d got=%h/%h exp=%h/%h", c, fetch_pc, fetch_instr, exp_pc, exp_instr); end
      end
      if (c == 6) begin
        checks++;
        if (dut.hold_v !== 1'b1) begin errors++; $display("FAIL rsthold_held got=%b exp=1", dut.hold_v); end
      end
      if (c == 10) begin
        checks++;
        if (!fetch_valid || fetch_pc !== 8'd0)
          begin errors++; $display("FAIL rsthold_refetch got=%b/%h exp=1/00", fetch_valid, fetch_pc); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    reset_cycle();
    for (int i = 0; i < 256; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 7))
        0:       op = 4'h0;
        1, 2:    op = 4'h3;
        3, 4:    op = 4'h4;
        5:       op = 4'h5;
        default: op = 4'h9;
      endcase
      rom[i] = {op, 12'($urandom)};
    end
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, 8'($urandom));
      checks += 2;
      if (fetch_valid !== exp_v) begin errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, fetch_valid, exp_v); end
      if (halted !== exp_halted) begin errors++; $display("FAIL rand_halted c=%0d got=%b exp=%b", c, halted, exp_halted); end
      if (exp_v) begin
        checks++;
        if ({fetch_pc, fetch_instr} !== {exp_pc, exp_instr})
          begin errors++; $display("FAIL rand_data c=%0d got=%h/%h exp=%h/%h", c, fetch_pc, fetch_instr, exp_pc, exp_instr); end
      end
      advance();
    end
  endtask

  initial begin
    prog = '{16'h300a, 16'h3100, 16'h3201, 16'h3300, 16'h4031, 16'h4012, 16'h5002, 16'h90fd, 16'h0000};
    test_reset();
    test_program();
    test_stall();
    test_redirect();
    test_halt_redirect();
    test_wrap();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
